// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router packet constants, state encoding and header builder
package router_pkg;

  localparam int MAX_LEN     = 63;
  localparam int ADDR_MAX    = 2;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_DONE
  } tx_state_t;

  // Header byte: length in the upper bits, destination address in the low bits.
  function automatic logic [7:0] hdr_make(input logic [LEN_W-1:0] len,
                                          input logic [HDR_ADDR_W-1:0] addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    h[HDR_ADDR_W-1:0] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// rtl/router_pkt_tx_if.sv - payload source and router input port bundle
interface router_pkt_tx_if;

  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       busy;

  // The transmitter drives the router port and the source ready.
  modport master (
    input  src_valid,
    input  src_data,
    output src_ready,
    output pkt_valid,
    output data_out,
    input  busy
  );

  // The environment supplies payload bytes and router back-pressure.
  modport slave (
    output src_valid,
    output src_data,
    input  src_ready,
    input  pkt_valid,
    input  data_out,
    output busy
  );

endinterface

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - single-clock payload staging buffer with combinational read
module router_tx_buf #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  // Write port; contents are never read before being written, so no reset.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read address comes from a register in the parent, so data is ready the same cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - stages a payload, then sends header, payload and parity to the router
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN_P  = MAX_LEN,
  parameter int ADDR_MAX_P = ADDR_MAX
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic [HDR_ADDR_W-1:0] dest_addr_i,
  input  logic [LEN_W-1:0]      pkt_len_i,
  input  logic                  corrupt_par_i,
  output logic                  tx_busy_o,
  output logic                  tx_done_o,
  output logic                  err_o,
  router_pkt_tx_if.master       bus
);

  localparam int PW = $clog2(MAX_LEN_P + 1);

  tx_state_t             state_q;
  logic [LEN_W-1:0]      len_q;
  logic [HDR_ADDR_W-1:0] addr_q;
  logic                  corrupt_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [7:0]            parity_q;
  logic                  src_ready_q;
  logic                  pkt_valid_q;
  logic [7:0]            data_out_q;
  logic                  tx_busy_q;
  logic                  tx_done_q;
  logic                  err_q;

  logic                  start_ok;
  logic                  buf_we;
  logic                  load_last;
  logic                  payload_last;
  logic [7:0]            buf_rdata;

  // Lengths are compared zero-extended so the range check stays unsigned for any MAX_LEN.
  assign start_ok = (pkt_len_i != '0) &&
                    (32'(pkt_len_i) <= 32'(MAX_LEN_P)) &&
                    (32'(dest_addr_i) <= 32'(ADDR_MAX_P));

  assign buf_we       = bus.src_valid & src_ready_q;
  assign load_last    = (wr_ptr_q == PW'(len_q - 1'b1));
  // rd_ptr_q runs one ahead of the byte on data_out; it equals len when the last byte is shown.
  assign payload_last = (rd_ptr_q == PW'(len_q));

  router_tx_buf #(
    .AW (PW),
    .DW (8)
  ) u_buf (
    .clock   (clock),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.src_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  // Packet sequencer: all router-facing outputs are registered and only move on a transfer.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      addr_q      <= '0;
      corrupt_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      parity_q    <= '0;
      src_ready_q <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= '0;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      tx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (start_ok) begin
              len_q       <= pkt_len_i;
              addr_q      <= dest_addr_i;
              corrupt_q   <= corrupt_par_i;
              wr_ptr_q    <= '0;
              rd_ptr_q    <= '0;
              parity_q    <= '0;
              src_ready_q <= 1'b1;
              tx_busy_q   <= 1'b1;
              state_q     <= ST_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (buf_we) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load_last) begin
              src_ready_q <= 1'b0;
              pkt_valid_q <= 1'b1;
              data_out_q  <= hdr_make(len_q, addr_q);
              state_q     <= ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (!bus.busy) begin
            parity_q   <= data_out_q;
            data_out_q <= buf_rdata;
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            state_q    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!bus.busy) begin
            parity_q <= parity_q ^ data_out_q;
            if (payload_last) begin
              pkt_valid_q <= 1'b0;
              data_out_q  <= parity_q ^ data_out_q ^ {8{corrupt_q}};
              state_q     <= ST_PARITY;
            end else begin
              data_out_q <= buf_rdata;
              rd_ptr_q   <= rd_ptr_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (!bus.busy) begin
            data_out_q <= '0;
            tx_done_q  <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          tx_busy_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.src_ready = src_ready_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.data_out  = data_out_q;
  assign tx_busy_o     = tx_busy_q;
  assign tx_done_o     = tx_done_q;
  assign err_o         = err_q;

endmodule
